// File: rtl/encoder4_2_seq.sv
// Sequential 4-to-2 priority encoder: request lines are latched into a pending
// register and issued one code at a time over a valid/ready handshake.
module encoder4_2_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       i_1,
   input  logic       i_2,
   input  logic       i_3,
   input  logic       i_4,
   input  logic       ready,
   output logic       o_1,
   output logic       o_2,
   output logic       valid,
   output logic [3:0] drop_cnt
);

   localparam int unsigned REQ_W  = 4;
   localparam int unsigned CODE_W = 2;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned SUM_W  = 3;
   localparam int unsigned ACC_W  = CNT_W + 1;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [REQ_W-1:0]    pend_q, pend_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [CNT_W-1:0]    drop_q, drop_d;

   logic [REQ_W-1:0]    req;
   logic [REQ_W-1:0]    clr;
   logic [REQ_W-1:0]    dropped;
   logic [CODE_W-1:0]   top_idx;
   logic [SUM_W-1:0]    drop_sum;
   logic [ACC_W-1:0]    drop_acc;
   logic                take;

   // Next-state: pick the highest pending index, merge new requests, count merges
   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      clr      = '0;
      top_idx  = '0;
      req      = en ? {i_4, i_3, i_2, i_1} : '0;

      if (pend_q[3])      top_idx = CODE_W'(3);
      else if (pend_q[2]) top_idx = CODE_W'(2);
      else if (pend_q[1]) top_idx = CODE_W'(1);
      else                top_idx = CODE_W'(0);

      take = ((state_q == IDLE) || ready) && (pend_q != '0);

      if (take) begin
         code_d  = top_idx;
         state_d = HOLD;
         clr     = REQ_W'(1) << top_idx;
      end else if ((state_q == HOLD) && ready) begin
         state_d = IDLE;
      end

      // A new request wins over the clear of the same bit in one edge
      pend_d   = (pend_q & ~clr) | req;
      dropped  = req & pend_q & ~clr;
      drop_sum = SUM_W'(dropped[0]) + SUM_W'(dropped[1])
               + SUM_W'(dropped[2]) + SUM_W'(dropped[3]);
      drop_acc = ACC_W'(drop_q) + ACC_W'(drop_sum);
      drop_d   = (drop_acc > ACC_W'(15)) ? CNT_W'(15) : CNT_W'(drop_acc);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         code_q  <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         code_q  <= code_d;
         drop_q  <= drop_d;
      end
   end

   assign o_1      = code_q[1];
   assign o_2      = code_q[0];
   assign valid    = (state_q == HOLD);
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_encoder4_2_seq.sv
// Scoreboard bench for encoder4_2_seq: stimulus queues expected codes, a
// negedge monitor pops and compares them on every accepted handshake.
module tb_encoder4_2_seq;

   logic       clk = 1'b0;
   logic       rst, en, i_1, i_2, i_3, i_4, ready;
   logic       o_1, o_2, valid;
   logic [3:0] drop_cnt;

   logic [1:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;

   encoder4_2_seq dut (
      .clk(clk), .rst(rst), .en(en),
      .i_1(i_1), .i_2(i_2), .i_3(i_3), .i_4(i_4),
      .ready(ready),
      .o_1(o_1), .o_2(o_2), .valid(valid), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Monitor: every accepted code must match the next queued expectation
   always @(negedge clk) begin
      if (!rst && valid && ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL handshake: got code %0d expected none queued at %0t",
                     {o_1, o_2}, $time);
         end else begin
            logic [1:0] e;
            e = exp_q.pop_front();
            if ({o_1, o_2} != e) begin
               errors++;
               $display("FAIL handshake: got code %0d expected %0d at %0t",
                        {o_1, o_2}, e, $time);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b1; ready = 1'b0;
      i_1 = 1'b0; i_2 = 1'b0; i_3 = 1'b0; i_4 = 1'b0;

      // Single request, held until accepted
      do_reset();
      chk("rst_valid", int'(valid), 0);
      chk("rst_code", int'({o_1, o_2}), 0);
      chk("rst_drop", int'(drop_cnt), 0);
      i_3 = 1'b1; exp_q.push_back(2'b10);
      tick();
      i_3 = 1'b0;
      chk("lat_valid0", int'(valid), 0);
      tick();
      chk("lat_valid1", int'(valid), 1);
      chk("lat_code", int'({o_1, o_2}), 2);
      tick(); tick(); tick();
      chk("hold_valid", int'(valid), 1);
      chk("hold_code", int'({o_1, o_2}), 2);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("acc_valid", int'(valid), 0);
      chk("acc_code_kept", int'({o_1, o_2}), 2);

      // Three simultaneous requests drained back to back
      ready = 1'b1;
      i_1 = 1'b1; i_2 = 1'b1; i_4 = 1'b1;
      exp_q.push_back(2'b11); exp_q.push_back(2'b01); exp_q.push_back(2'b00);
      tick();
      i_1 = 1'b0; i_2 = 1'b0; i_4 = 1'b0;
      chk("b2b_v0", int'(valid), 0);
      tick();
      chk("b2b_c1", int'({valid, o_1, o_2}), 7);
      tick();
      chk("b2b_c2", int'({valid, o_1, o_2}), 5);
      tick();
      chk("b2b_c3", int'({valid, o_1, o_2}), 4);
      tick();
      chk("b2b_end", int'(valid), 0);
      chk("b2b_drop", int'(drop_cnt), 0);

      // Enable low: request ignored entirely
      en = 1'b0; i_2 = 1'b1;
      tick();
      i_2 = 1'b0; en = 1'b1;
      tick(); tick(); tick();
      chk("en0_valid", int'(valid), 0);
      chk("en0_drop", int'(drop_cnt), 0);
      ready = 1'b0;

      // Merged request while a code is held
      do_reset();
      i_1 = 1'b1; exp_q.push_back(2'b00);
      tick();
      i_1 = 1'b0;
      tick();
      i_4 = 1'b1; exp_q.push_back(2'b11);
      tick();
      tick();
      i_4 = 1'b0;
      chk("merge_code", int'({valid, o_1, o_2}), 4);
      chk("merge_drop", int'(drop_cnt), 1);
      ready = 1'b1;
      tick();
      chk("merge_next", int'({valid, o_1, o_2}), 7);
      tick();
      ready = 1'b0;
      chk("merge_idle", int'(valid), 0);
      chk("merge_drop2", int'(drop_cnt), 1);

      // Continuous request while blocked: counter saturates
      do_reset();
      i_2 = 1'b1; exp_q.push_back(2'b01);
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 10) chk("sat_mid", int'(drop_cnt), 8);
      end
      i_2 = 1'b0;
      chk("sat_drop", int'(drop_cnt), 15);
      chk("sat_code", int'({valid, o_1, o_2}), 5);
      exp_q.push_back(2'b01);
      ready = 1'b1;
      tick();
      chk("sat_reissue", int'({valid, o_1, o_2}), 5);
      tick();
      ready = 1'b0;
      chk("sat_idle", int'(valid), 0);
      chk("sat_hold15", int'(drop_cnt), 15);

      // Reset while holding with requests pending abandons everything
      do_reset();
      i_1 = 1'b1;
      tick();
      i_1 = 1'b0;
      tick();
      i_4 = 1'b1; i_2 = 1'b1;
      tick();
      i_4 = 1'b0; i_2 = 1'b0;
      chk("pre_rst_valid", int'(valid), 1);
      rst = 1'b1; i_3 = 1'b1;
      tick();
      rst = 1'b0; i_3 = 1'b0;
      chk("hrst_valid", int'(valid), 0);
      chk("hrst_code", int'({o_1, o_2}), 0);
      chk("hrst_drop", int'(drop_cnt), 0);
      ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("hrst_quiet", int'(valid), 0);
      end
      ready = 1'b0;

      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
